memory_path: RTL and testbench

- Memory stage of the five-stage pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and drives the data-memory request/acknowledge handshake for loads and stores.
- Handles variable-latency memory with a stall output and a timeout.
- Holds the MEM/WB pipeline register feeding writeback, and exposes M-stage values for forwarding.

---
 rtl/memory_path.sv | 185 ++++++++++++++++++
 tb/tb_memory_path.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_path.sv
// rtl/memory_path.sv - memory stage: EX/MEM register, dmem handshake with stall/timeout, MEM/WB register
module memory_path #(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] alu_out_E,
  input  logic [N-1:0] write_data_E,
  input  logic [4:0]   reg_id_E,
  input  logic         reg_write_E,
  input  logic         mem_to_reg_E,
  input  logic         mem_write_E,
  input  logic         flush_E,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  input  logic         dmem_ack,
  input  logic [N-1:0] dmem_rdata,
  output logic         stall_M,
  output logic [N-1:0] alu_out_M,
  output logic [4:0]   reg_id_M,
  output logic         reg_write_M,
  output logic [N-1:0] alu_out_W,
  output logic [N-1:0] read_data_W,
  output logic [4:0]   reg_id_W,
  output logic         reg_write_W,
  output logic         mem_to_reg_W,
  output logic         align_err,
  output logic         bus_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;

  logic [N-1:0] m_alu_q, m_alu_d;
  logic [N-1:0] m_wdata_q, m_wdata_d;
  logic [4:0]   m_rid_q, m_rid_d;
  logic         m_rw_q, m_rw_d;
  logic         m_m2r_q, m_m2r_d;
  logic         m_mw_q, m_mw_d;
  logic         m_aerr_q, m_aerr_d;

  logic [N-1:0] w_alu_q, w_alu_d;
  logic [N-1:0] w_rdata_q, w_rdata_d;
  logic [4:0]   w_rid_q, w_rid_d;
  logic         w_rw_q, w_rw_d;
  logic         w_m2r_q, w_m2r_d;

  logic         access;
  logic         timeout;
  logic         stall;
  logic         e_mem;
  logic         e_misaligned;
  logic         e_starts_access;

  // Handshake status: an ack only counts while a request is actually outstanding
  always_comb begin
    access          = (state_q == ACCESS);
    timeout         = access && !dmem_ack && (cnt_q == WAIT_LAST);
    stall           = access && !dmem_ack && !timeout;
    e_mem           = mem_to_reg_E || mem_write_E;
    e_misaligned    = e_mem && (alu_out_E[1:0] != 2'b00);
    e_starts_access = !flush_E && e_mem && !e_misaligned;
  end

  // Next EX/MEM contents: hold on stall, otherwise capture E, a flush bubble or an alignment bubble
  always_comb begin
    m_alu_d   = m_alu_q;
    m_wdata_d = m_wdata_q;
    m_rid_d   = m_rid_q;
    m_rw_d    = m_rw_q;
    m_m2r_d   = m_m2r_q;
    m_mw_d    = m_mw_q;
    m_aerr_d  = m_aerr_q;
    if (!stall) begin
      m_alu_d   = '0;
      m_wdata_d = '0;
      m_rid_d   = '0;
      m_rw_d    = 1'b0;
      m_m2r_d   = 1'b0;
      m_mw_d    = 1'b0;
      m_aerr_d  = 1'b0;
      if (!flush_E) begin
        if (e_misaligned) begin
          m_aerr_d = 1'b1;
        end else begin
          m_alu_d   = alu_out_E;
          m_wdata_d = write_data_E;
          m_rid_d   = reg_id_E;
          m_rw_d    = reg_write_E;
          m_m2r_d   = mem_to_reg_E;
          m_mw_d    = mem_write_E;
        end
      end
    end
  end

  // Access FSM and wait counter: a new access starts whenever an aligned mem op is loaded into M
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stall) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d   = 8'd0;
      state_d = e_starts_access ? ACCESS : IDLE;
    end
  end

  // Next MEM/WB contents: bubbles for stalled or timed-out accesses so nothing retires twice
  always_comb begin
    w_alu_d   = '0;
    w_rdata_d = '0;
    w_rid_d   = '0;
    w_rw_d    = 1'b0;
    w_m2r_d   = 1'b0;
    if (!stall && !timeout) begin
      w_alu_d   = m_alu_q;
      w_rid_d   = m_rid_q;
      w_rw_d    = m_rw_q;
      w_m2r_d   = m_m2r_q;
      w_rdata_d = (access && dmem_ack && m_m2r_q) ? dmem_rdata : '0;
    end
  end

  // State registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      m_alu_q   <= '0;
      m_wdata_q <= '0;
      m_rid_q   <= '0;
      m_rw_q    <= 1'b0;
      m_m2r_q   <= 1'b0;
      m_mw_q    <= 1'b0;
      m_aerr_q  <= 1'b0;
      w_alu_q   <= '0;
      w_rdata_q <= '0;
      w_rid_q   <= '0;
      w_rw_q    <= 1'b0;
      w_m2r_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_alu_q   <= m_alu_d;
      m_wdata_q <= m_wdata_d;
      m_rid_q   <= m_rid_d;
      m_rw_q    <= m_rw_d;
      m_m2r_q   <= m_m2r_d;
      m_mw_q    <= m_mw_d;
      m_aerr_q  <= m_aerr_d;
      w_alu_q   <= w_alu_d;
      w_rdata_q <= w_rdata_d;
      w_rid_q   <= w_rid_d;
      w_rw_q    <= w_rw_d;
      w_m2r_q   <= w_m2r_d;
    end
  end

  assign dmem_req     = access;
  assign dmem_we      = access && m_mw_q;
  assign dmem_addr    = access ? m_alu_q : '0;
  assign dmem_wdata   = access ? m_wdata_q : '0;
  assign stall_M      = stall;
  assign bus_err      = timeout;
  assign align_err    = m_aerr_q;

  assign alu_out_M    = m_alu_q;
  assign reg_id_M     = m_rid_q;
  assign reg_write_M  = m_rw_q;

  assign alu_out_W    = w_alu_q;
  assign read_data_W  = w_rdata_q;
  assign reg_id_W     = w_rid_q;
  assign reg_write_W  = w_rw_q;
  assign mem_to_reg_W = w_m2r_q;

endmodule

// File: tb/tb_memory_path.sv
// tb/tb_memory_path.sv - directed vector bench for memory_path
module tb_memory_path;

  localparam int K_NOP = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_ALU = 3;

  logic        clk;
  logic        reset_n;
  logic [31:0] alu_out_E, write_data_E;
  logic [4:0]  reg_id_E;
  logic        reg_write_E, mem_to_reg_E, mem_write_E, flush_E;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_M;
  logic [31:0] alu_out_M;
  logic [4:0]  reg_id_M;
  logic        reg_write_M;
  logic [31:0] alu_out_W, read_data_W;
  logic [4:0]  reg_id_W;
  logic        reg_write_W, mem_to_reg_W;
  logic        align_err, bus_err;

  int n_vec;
  int n_err;

  typedef struct {
    string       nm;
    logic        fl;
    int          kind;
    logic [31:0] ae;
    logic [31:0] wd;
    logic [4:0]  rid;
    logic        ack;
    logic [31:0] rd;
    logic [145:0] exp;
  } vec_t;

  vec_t tbl[$];

  memory_path #(.N(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_out_E(alu_out_E), .write_data_E(write_data_E), .reg_id_E(reg_id_E),
    .reg_write_E(reg_write_E), .mem_to_reg_E(mem_to_reg_E), .mem_write_E(mem_write_E),
    .flush_E(flush_E),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_M(stall_M), .alu_out_M(alu_out_M), .reg_id_M(reg_id_M), .reg_write_M(reg_write_M),
    .alu_out_W(alu_out_W), .read_data_W(read_data_W), .reg_id_W(reg_id_W),
    .reg_write_W(reg_write_W), .mem_to_reg_W(mem_to_reg_W),
    .align_err(align_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [145:0] ex(
      logic req, logic we, logic [31:0] addr, logic [31:0] wdat, logic st, logic ae, logic be,
      logic [4:0] ridm, logic rwm, logic [31:0] aluw, logic [31:0] rdw, logic [4:0] ridw,
      logic rww, logic m2rw);
    return {req, we, addr, wdat, st, ae, be, ridm, rwm, aluw, rdw, ridw, rww, m2rw};
  endfunction

  function automatic vec_t v(string nm, logic fl, int kind, logic [31:0] ae, logic [31:0] wd,
                             logic [4:0] rid, logic ack, logic [31:0] rd, logic [145:0] e);
    vec_t r;
    r.nm = nm; r.fl = fl; r.kind = kind; r.ae = ae; r.wd = wd;
    r.rid = rid; r.ack = ack; r.rd = rd; r.exp = e;
    return r;
  endfunction

  function automatic logic [145:0] got();
    return {dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_M, align_err, bus_err,
            reg_id_M, reg_write_M, alu_out_W, read_data_W, reg_id_W, reg_write_W, mem_to_reg_W};
  endfunction

  task automatic drive(logic fl, int kind, logic [31:0] ae, logic [31:0] wd, logic [4:0] rid,
                       logic ack, logic [31:0] rd);
    flush_E      = fl;
    alu_out_E    = ae;
    write_data_E = wd;
    reg_id_E     = rid;
    reg_write_E  = (kind == K_LD) || (kind == K_ALU);
    mem_to_reg_E = (kind == K_LD);
    mem_write_E  = (kind == K_ST);
    dmem_ack     = ack;
    dmem_rdata   = rd;
  endtask

  task automatic chk(string nm, logic [145:0] e);
    logic [145:0] a;
    a = got();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  initial begin
    logic [145:0] z;
    logic [145:0] wait_st;
    logic [145:0] wait_to;
    logic [145:0] wait_b2b;
    n_vec = 0;
    n_err = 0;
    z = '0;
    wait_st  = ex(1, 1, 32'h100, 32'h12345678, 1, 0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    wait_to  = ex(1, 0, 32'h200, 32'h0, 1, 0, 0, 5'd4, 1, 0, 0, 5'd0, 0, 0);
    wait_b2b = ex(1, 1, 32'h84, 32'hCAFEF00D, 1, 0, 0, 5'd0, 0,
                  32'h80, 32'h11223344, 5'd10, 1, 1);

    tbl.push_back(v("reset",        0, K_NOP, 0, 0, 0, 0, 0, z));
    tbl.push_back(v("ld_issue",     0, K_LD, 32'h40, 0, 5'd5, 0, 0, z));
    tbl.push_back(v("ld_zero_wait", 0, K_NOP, 0, 0, 0, 1, 32'hDEADBEEF,
                    ex(1, 0, 32'h40, 0, 0, 0, 0, 5'd5, 1, 0, 0, 5'd0, 0, 0)));
    tbl.push_back(v("ld_retire",    0, K_NOP, 0, 0, 0, 0, 0,
                    ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 32'h40, 32'hDEADBEEF, 5'd5, 1, 1)));
    tbl.push_back(v("st_issue",     0, K_ST, 32'h100, 32'h12345678, 0, 0, 0, z));
    tbl.push_back(v("st_wait1",     0, K_ALU, 32'h99, 0, 5'd3, 0, 0, wait_st));
    tbl.push_back(v("st_wait2_fl",  1, K_ALU, 32'h99, 0, 5'd3, 0, 0, wait_st));
    tbl.push_back(v("st_wait3",     0, K_ALU, 32'h99, 0, 5'd3, 0, 0, wait_st));
    tbl.push_back(v("st_ack",       0, K_ALU, 32'h99, 0, 5'd3, 1, 32'hA5A5A5A5,
                    ex(1, 1, 32'h100, 32'h12345678, 0, 0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0)));
    tbl.push_back(v("st_retire",    0, K_NOP, 0, 0, 0, 0, 0,
                    ex(0, 0, 0, 0, 0, 0, 0, 5'd3, 1, 32'h100, 0, 5'd0, 0, 0)));
    tbl.push_back(v("mis_issue",    0, K_LD, 32'h42, 0, 5'd9, 0, 0,
                    ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 32'h99, 0, 5'd3, 1, 0)));
    tbl.push_back(v("mis_in_m",     0, K_NOP, 0, 0, 0, 0, 0,
                    ex(0, 0, 0, 0, 0, 1, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0)));
    tbl.push_back(v("mis_retire",   0, K_NOP, 0, 0, 0, 0, 0, z));
    tbl.push_back(v("to_issue",     0, K_LD, 32'h200, 0, 5'd4, 0, 0, z));
    tbl.push_back(v("to_wait1",     0, K_ALU, 32'h55, 0, 5'd7, 0, 0, wait_to));
    tbl.push_back(v("to_wait2",     0, K_ALU, 32'h55, 0, 5'd7, 0, 0, wait_to));
    tbl.push_back(v("to_wait3",     0, K_ALU, 32'h55, 0, 5'd7, 0, 0, wait_to));
    tbl.push_back(v("to_abort",     0, K_ALU, 32'h55, 0, 5'd7, 0, 0,
                    ex(1, 0, 32'h200, 0, 0, 0, 1, 5'd4, 1, 0, 0, 5'd0, 0, 0)));
    tbl.push_back(v("to_stray_ack", 0, K_NOP, 0, 0, 0, 1, 32'h77777777,
                    ex(0, 0, 0, 0, 0, 0, 0, 5'd7, 1, 0, 0, 5'd0, 0, 0)));
    tbl.push_back(v("to_alu_ret",   0, K_NOP, 0, 0, 0, 0, 0,
                    ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 32'h55, 0, 5'd7, 1, 0)));
    tbl.push_back(v("b2b_ld_issue", 0, K_LD, 32'h80, 0, 5'd10, 0, 0, z));
    tbl.push_back(v("b2b_ld_ack",   0, K_ST, 32'h84, 32'hCAFEF00D, 0, 1, 32'h11223344,
                    ex(1, 0, 32'h80, 0, 0, 0, 0, 5'd10, 1, 0, 0, 5'd0, 0, 0)));
    tbl.push_back(v("b2b_st_wait",  0, K_ALU, 32'h33, 0, 5'd12, 0, 0, wait_b2b));
    tbl.push_back(v("b2b_st_ack",   0, K_ALU, 32'h33, 0, 5'd12, 1, 32'hFFFFFFFF,
                    ex(1, 1, 32'h84, 32'hCAFEF00D, 0, 0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0)));
    tbl.push_back(v("b2b_st_ret",   0, K_NOP, 0, 0, 0, 0, 0,
                    ex(0, 0, 0, 0, 0, 0, 0, 5'd12, 1, 32'h84, 0, 5'd0, 0, 0)));
    tbl.push_back(v("b2b_alu_ret",  0, K_NOP, 0, 0, 0, 0, 0,
                    ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 32'h33, 0, 5'd12, 1, 0)));

    reset_n = 1'b0;
    drive(0, K_NOP, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].fl, tbl[i].kind, tbl[i].ae, tbl[i].wd, tbl[i].rid, tbl[i].ack, tbl[i].rd);
      #1;
      chk(tbl[i].nm, tbl[i].exp);
    end

    // Reset asserted during the second wait cycle of a load
    @(negedge clk);
    drive(0, K_LD, 32'h300, 0, 5'd6, 0, 0);
    @(negedge clk);
    drive(0, K_NOP, 0, 0, 0, 0, 0);
    #1;
    chk("rst_wait1", ex(1, 0, 32'h300, 0, 1, 0, 0, 5'd6, 1, 0, 0, 5'd0, 0, 0));
    @(negedge clk);
    #1;
    chk("rst_wait2", ex(1, 0, 32'h300, 0, 1, 0, 0, 5'd6, 1, 0, 0, 5'd0, 0, 0));
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_async", z);
    n_vec++;
    if (alu_out_M !== 32'h0) begin
      n_err++;
      $display("FAIL rst_alu_m: got %h want %h", alu_out_M, 32'h0);
    end
    @(negedge clk);
    #1;
    chk("rst_held", z);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_after1", z);
    @(negedge clk);
    #1;
    chk("rst_after2", z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
